// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_pkg
//  Description : Shared definitions for the NoC receive path: flit type codes,
//                header field offsets, reassembler FSM states, clog2 helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Flit type encodings carried on the flit type sideband
  localparam int c_flit_header      = 0;
  localparam int c_flit_body        = 1;
  localparam int c_flit_tail        = 2;
  localparam int c_flit_header_tail = 3;

  // Reassembler FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Header layout, LSB first: src_id, tdest, tid, last_bytes
  function automatic int hdr_tdest_lsb(input int src_w);
    return src_w;
  endfunction

  function automatic int hdr_tid_lsb(input int src_w, input int tdest_w);
    return src_w + tdest_w;
  endfunction

  function automatic int hdr_last_bytes_lsb(input int src_w, input int tdest_w, input int tid_w);
    return src_w + tdest_w + tid_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buffer
//  Description : Two-entry output FIFO. Slot 0 drives the stream outputs
//                directly from a register; up to two beats can be written per
//                cycle (the second only when the buffer drains to empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push0_valid,
  input  logic [WIDTH-1:0] i_push0_data,
  input  logic             i_push1_valid,
  input  logic [WIDTH-1:0] i_push1_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic [1:0]       o_count,
  output logic [1:0]       o_count_next
);

  logic [WIDTH-1:0] r_slot0;
  logic [WIDTH-1:0] r_slot1;
  logic [1:0]       r_count;

  logic             w_pop;
  logic [1:0]       w_base_count;
  logic [WIDTH-1:0] w_slot0_next;
  logic [WIDTH-1:0] w_slot1_next;

  assign o_valid      = (r_count != 2'd0);
  assign o_data       = r_slot0;
  assign o_count      = r_count;
  assign w_pop        = o_valid && i_ready;
  assign w_base_count = r_count - {1'b0, w_pop};
  assign o_count_next = w_base_count + {1'b0, i_push0_valid} + {1'b0, i_push1_valid};

  // Shift out the popped head, then append new beats behind what remains
  always_comb begin
    w_slot0_next = w_pop ? r_slot1 : r_slot0;
    w_slot1_next = r_slot1;
    case (w_base_count)
      2'd0: begin
        if (i_push0_valid) w_slot0_next = i_push0_data;
        if (i_push1_valid) w_slot1_next = i_push1_data;
      end
      2'd1: begin
        if (i_push0_valid) w_slot1_next = i_push0_data;
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else begin
      r_slot0 <= w_slot0_next;
      r_slot1 <= w_slot1_next;
      r_count <= o_count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_packet_reassembler.sv
`default_nettype none
// ============================================================================
//  Module      : noc_packet_reassembler
//  Description : Converts ejected NoC flits into AXI-Stream beats. Headers are
//                stripped and their metadata attached to every beat; malformed
//                flit sequences are dropped and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_packet_reassembler
  import noc_pkg::*;
#(
  parameter int NetworkIfFlitWidth             = 64,
  parameter int NetworkIfFlitTypeWidth         = 2,
  parameter int NetworkIfBroadcastWidth        = 1,
  parameter int NetworkIfVirtualChannelIdWidth = 1,
  parameter int AxiStreamIfTIdWidth            = 4,
  parameter int AxiStreamIfTDestWidth          = 4,
  parameter int SourceIdWidth                  = 8
) (
  input  logic                                      clk_network_i,
  input  logic                                      rst_network_ni,
  input  logic                                      network_valid_i,
  output logic                                      network_ready_o,
  input  logic [NetworkIfFlitWidth-1:0]             network_flit_i,
  input  logic [NetworkIfFlitTypeWidth-1:0]         network_flit_type_i,
  input  logic [NetworkIfBroadcastWidth-1:0]        network_broadcast_i,
  input  logic [NetworkIfVirtualChannelIdWidth-1:0] network_virtual_channel_id_i,
  output logic                                      m_axis_tvalid_o,
  input  logic                                      m_axis_tready_i,
  output logic [NetworkIfFlitWidth-1:0]             m_axis_tdata_o,
  output logic [NetworkIfFlitWidth/8-1:0]           m_axis_tkeep_o,
  output logic                                      m_axis_tlast_o,
  output logic [AxiStreamIfTIdWidth-1:0]            m_axis_tid_o,
  output logic [AxiStreamIfTDestWidth-1:0]          m_axis_tdest_o,
  output logic [SourceIdWidth-1:0]                  m_axis_tuser_o,
  output logic [15:0]                               drop_count_o
);

  localparam int c_flit_bytes = NetworkIfFlitWidth / 8;
  localparam int c_lb_w       = clog2(c_flit_bytes) + 1;
  localparam int c_tdest_lsb  = hdr_tdest_lsb(SourceIdWidth);
  localparam int c_tid_lsb    = hdr_tid_lsb(SourceIdWidth, AxiStreamIfTDestWidth);
  localparam int c_lb_lsb     = hdr_last_bytes_lsb(SourceIdWidth, AxiStreamIfTDestWidth, AxiStreamIfTIdWidth);
  localparam int c_beat_w     = NetworkIfFlitWidth + c_flit_bytes + 1 + AxiStreamIfTIdWidth
                                + AxiStreamIfTDestWidth + SourceIdWidth;

  localparam logic [NetworkIfFlitTypeWidth-1:0] c_ft_header      = NetworkIfFlitTypeWidth'(c_flit_header);
  localparam logic [NetworkIfFlitTypeWidth-1:0] c_ft_body        = NetworkIfFlitTypeWidth'(c_flit_body);
  localparam logic [NetworkIfFlitTypeWidth-1:0] c_ft_tail        = NetworkIfFlitTypeWidth'(c_flit_tail);
  localparam logic [NetworkIfFlitTypeWidth-1:0] c_ft_header_tail = NetworkIfFlitTypeWidth'(c_flit_header_tail);

  // Latched header of the open packet
  state_e                           r_state;
  logic [SourceIdWidth-1:0]         r_src_id;
  logic [AxiStreamIfTDestWidth-1:0] r_tdest;
  logic [AxiStreamIfTIdWidth-1:0]   r_tid;
  logic [c_lb_w-1:0]                r_last_bytes;
  logic [15:0]                      r_drop_count;
  logic                             r_ready;

  // Header fields of the incoming flit
  logic [SourceIdWidth-1:0]         w_hdr_src;
  logic [AxiStreamIfTDestWidth-1:0] w_hdr_tdest;
  logic [AxiStreamIfTIdWidth-1:0]   w_hdr_tid;
  logic [c_lb_w-1:0]                w_hdr_last_bytes;

  logic                             w_is_header;
  logic                             w_is_header_tail;
  logic                             w_is_body;
  logic                             w_is_tail;
  logic                             w_is_hdr_any;
  logic                             w_trunc_stall;
  logic                             w_accept;
  logic                             w_drop;

  logic [c_flit_bytes-1:0]          w_tail_keep;
  logic [c_beat_w-1:0]              w_body_beat;
  logic [c_beat_w-1:0]              w_tail_beat;
  logic [c_beat_w-1:0]              w_close_beat;
  logic [c_beat_w-1:0]              w_ht_beat;
  logic                             w_push0_valid;
  logic                             w_push1_valid;
  logic [c_beat_w-1:0]              w_push0_beat;
  logic [c_beat_w-1:0]              w_push1_beat;
  logic [c_beat_w-1:0]              w_out_beat;
  logic [1:0]                       w_count;
  logic [1:0]                       w_count_next;

  // Broadcast and VC sidebands carry no meaning here: single VC, broadcast treated as unicast
  logic                             w_unused_bits;
  assign w_unused_bits = ^{network_broadcast_i, network_virtual_channel_id_i};

  assign w_hdr_src        = network_flit_i[SourceIdWidth-1:0];
  assign w_hdr_tdest      = network_flit_i[c_tdest_lsb +: AxiStreamIfTDestWidth];
  assign w_hdr_tid        = network_flit_i[c_tid_lsb +: AxiStreamIfTIdWidth];
  assign w_hdr_last_bytes = network_flit_i[c_lb_lsb +: c_lb_w];

  assign w_is_header      = (network_flit_type_i == c_ft_header);
  assign w_is_header_tail = (network_flit_type_i == c_ft_header_tail);
  assign w_is_body        = (network_flit_type_i == c_ft_body);
  assign w_is_tail        = (network_flit_type_i == c_ft_tail);
  assign w_is_hdr_any     = w_is_header || w_is_header_tail;

  // A header arriving mid-packet closes the old packet and may open a null
  // beat of its own, so it waits until both buffer slots are free.
  assign w_trunc_stall    = (r_state == ST_PAYLOAD) && w_is_hdr_any && (w_count != 2'd0);
  assign network_ready_o  = r_ready && !w_trunc_stall;
  assign w_accept         = network_valid_i && network_ready_o;

  // Orphan body/tail outside a packet, and the truncated remainder of an open packet
  assign w_drop = w_accept && (((r_state != ST_PAYLOAD) && (w_is_body || w_is_tail)) ||
                               ((r_state == ST_PAYLOAD) && w_is_hdr_any));

  // Final-flit byte mask: contiguous from byte 0, zero length means a full flit
  always_comb begin
    int lb_eff;
    lb_eff = (r_last_bytes == '0) ? c_flit_bytes : int'(r_last_bytes);
    for (int i = 0; i < c_flit_bytes; i++) begin
      w_tail_keep[i] = (i < lb_eff);
    end
  end

  assign w_body_beat  = {network_flit_i, {c_flit_bytes{1'b1}}, 1'b0, r_tid, r_tdest, r_src_id};
  assign w_tail_beat  = {network_flit_i, w_tail_keep, 1'b1, r_tid, r_tdest, r_src_id};
  assign w_close_beat = {{NetworkIfFlitWidth{1'b0}}, {c_flit_bytes{1'b0}}, 1'b1, r_tid, r_tdest, r_src_id};
  assign w_ht_beat    = {{NetworkIfFlitWidth{1'b0}}, {c_flit_bytes{1'b0}}, 1'b1, w_hdr_tid, w_hdr_tdest, w_hdr_src};

  // Select the beat(s) produced by the accepted flit
  always_comb begin
    w_push0_valid = 1'b0;
    w_push1_valid = 1'b0;
    w_push0_beat  = w_ht_beat;
    w_push1_beat  = w_ht_beat;
    if (w_accept) begin
      if (r_state == ST_PAYLOAD) begin
        w_push0_valid = 1'b1;
        if (w_is_body) begin
          w_push0_beat = w_body_beat;
        end else if (w_is_tail) begin
          w_push0_beat = w_tail_beat;
        end else begin
          w_push0_beat  = w_close_beat;
          w_push1_valid = w_is_header_tail;
        end
      end else if (w_is_header_tail) begin
        w_push0_valid = 1'b1;
      end
    end
  end

  // Packet FSM, header latch, drop counter and registered flit-ready
  always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
    if (!rst_network_ni) begin
      r_state      <= ST_IDLE;
      r_src_id     <= '0;
      r_tdest      <= '0;
      r_tid        <= '0;
      r_last_bytes <= '0;
      r_drop_count <= 16'd0;
      r_ready      <= 1'b0;
    end else begin
      r_ready <= (w_count_next < 2'd2);
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_accept) begin
        case (network_flit_type_i)
          c_ft_header: begin
            r_src_id     <= w_hdr_src;
            r_tdest      <= w_hdr_tdest;
            r_tid        <= w_hdr_tid;
            r_last_bytes <= w_hdr_last_bytes;
            r_state      <= ST_PAYLOAD;
          end
          c_ft_header_tail: r_state <= ST_IDLE;
          c_ft_tail:        r_state <= ST_IDLE;
          c_ft_body: begin
            if (r_state == ST_IDLE) r_state <= ST_DROP;
          end
          default: ;
        endcase
      end
    end
  end

  axis_skid_buffer #(
    .WIDTH (c_beat_w)
  ) u_skid (
    .clk           (clk_network_i),
    .rst_n         (rst_network_ni),
    .i_push0_valid (w_push0_valid),
    .i_push0_data  (w_push0_beat),
    .i_push1_valid (w_push1_valid),
    .i_push1_data  (w_push1_beat),
    .o_valid       (m_axis_tvalid_o),
    .o_data        (w_out_beat),
    .i_ready       (m_axis_tready_i),
    .o_count       (w_count),
    .o_count_next  (w_count_next)
  );

  assign {m_axis_tdata_o, m_axis_tkeep_o, m_axis_tlast_o,
          m_axis_tid_o, m_axis_tdest_o, m_axis_tuser_o} = w_out_beat;
  assign drop_count_o = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_noc_packet_reassembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_noc_packet_reassembler
//  Description : Directed and randomly back-pressured stimulus for the NoC
//                packet reassembler with a bench-side expected beat queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_packet_reassembler;

  localparam logic [1:0] T_H  = 2'd0;
  localparam logic [1:0] T_B  = 2'd1;
  localparam logic [1:0] T_T  = 2'd2;
  localparam logic [1:0] T_HT = 2'd3;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  tid;
    logic [3:0]  tdest;
    logic [7:0]  user;
  } beat_t;

  typedef struct {
    logic [1:0]  ftype;
    logic [63:0] fdata;
    bit          has_beat;
    beat_t       beat;
    int          exp_drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [63:0] flit;
  logic [1:0]  ftype;
  logic [0:0]  bcast;
  logic [0:0]  vc;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic [3:0]  tid;
  logic [3:0]  tdest;
  logic [7:0]  tuser;
  logic [15:0] drop;

  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;
  bit    bp_en  = 1'b0;
  bit    tready_idle = 1'b1;
  beat_t got_q[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  noc_packet_reassembler dut (
    .clk_network_i                (clk),
    .rst_network_ni               (rst_n),
    .network_valid_i              (valid),
    .network_ready_o              (ready),
    .network_flit_i               (flit),
    .network_flit_type_i          (ftype),
    .network_broadcast_i          (bcast),
    .network_virtual_channel_id_i (vc),
    .m_axis_tvalid_o              (tvalid),
    .m_axis_tready_i              (tready),
    .m_axis_tdata_o               (tdata),
    .m_axis_tkeep_o               (tkeep),
    .m_axis_tlast_o               (tlast),
    .m_axis_tid_o                 (tid),
    .m_axis_tdest_o               (tdest),
    .m_axis_tuser_o               (tuser),
    .drop_count_o                 (drop)
  );

  // Sink ready: random under back-pressure, otherwise a fixed level
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = bp_en ? 1'($urandom_range(0, 1)) : tready_idle;
    end
  end

  // Output monitor: collects accepted beats and checks a stalled beat holds
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    cur = {tdata, tkeep, tlast, tid, tdest, tuser};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!tvalid || cur != prev_beat) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b beat=%h required valid=1 beat=%h", tvalid, cur, prev_beat);
        end
      end
      if (tvalid && tready) got_q.push_back(cur);
      prev_stall = tvalid && !tready;
      prev_beat  = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] hdr(input logic [7:0] s, input logic [3:0] dst,
                                      input logic [3:0] id, input logic [3:0] lb);
    return {44'd0, lb, id, dst, s};
  endfunction

  function automatic logic [7:0] keep_of(input int lb);
    int n;
    logic [7:0] k;
    n = (lb == 0) ? 8 : lb;
    k = 8'h00;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k, input logic l,
                               input logic [3:0] id, input logic [3:0] dst, input logic [7:0] u);
    beat_t b;
    b.data = d; b.keep = k; b.last = l; b.tid = id; b.tdest = dst; b.user = u;
    return b;
  endfunction

  function automatic vec_t v(input logic [1:0] t, input logic [63:0] d, input bit hb,
                             input beat_t b, input int dr);
    vec_t r;
    r.ftype = t; r.fdata = d; r.has_beat = hb; r.beat = b; r.exp_drop = dr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Present one flit, starting #1 after a rising edge; returns #1 after the accepting edge
  task automatic send_flit(input logic [1:0] t, input logic [63:0] d);
    bit done;
    int waited;
    valid = 1'b1; ftype = t; flit = d;
    done = 1'b0; waited = 0;
    while (!done) begin
      @(negedge clk);
      done = ready;
      @(posedge clk);
      #1;
      waited++;
      if (!done && waited > 500) begin
        checks++; errors++;
        $display("FAIL send_timeout: got ready=0 for %0d cycles required ready=1", waited);
        done = 1'b1;
      end
    end
    valid = 1'b0;
  endtask

  task automatic drain_and_compare(input string name);
    int n;
    n = 0;
    while ((got_q.size() < exp_q.size() || tvalid) && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_beat_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("FAIL %s_beat[%0d]: got none required %h", name, i, exp_q[i]);
      end else if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL %s_beat[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = v(T_H,  hdr(8'h12, 4'd3, 4'd5, 4'd3), 0, '0, 0);
    tbl[1] = v(T_B,  64'h0807060504030201, 1, mk(64'h0807060504030201, 8'hFF, 1'b0, 4'd5, 4'd3, 8'h12), 0);
    tbl[2] = v(T_T,  64'h00000000000B0A09, 1, mk(64'h00000000000B0A09, 8'h07, 1'b1, 4'd5, 4'd3, 8'h12), 0);
    tbl[3] = v(T_HT, hdr(8'h01, 4'd2, 4'd6, 4'd0), 1, mk(64'd0, 8'h00, 1'b1, 4'd6, 4'd2, 8'h01), 0);
    tbl[4] = v(T_B,  64'hDEAD0001, 0, '0, 1);
    tbl[5] = v(T_B,  64'hDEAD0002, 0, '0, 2);
    tbl[6] = v(T_T,  64'hDEAD0003, 0, '0, 3);
    tbl[7] = v(T_H,  hdr(8'h34, 4'hA, 4'h9, 4'd0), 0, '0, 3);
    tbl[8] = v(T_T,  64'h1122334455667788, 1, mk(64'h1122334455667788, 8'hFF, 1'b1, 4'h9, 4'hA, 8'h34), 3);

    rst_n = 1'b0; valid = 1'b0; flit = '0; ftype = '0; bcast = '0; vc = '0;

    // Reset state
    #3;
    chk("reset_ready",  {63'd0, ready},  64'd0);
    chk("reset_tvalid", {63'd0, tvalid}, 64'd0);
    chk("reset_tdata",  tdata, 64'd0);
    chk("reset_meta",   {36'd0, tkeep, tid, tdest, tuser}, 64'd0);
    chk("reset_drop",   {48'd0, drop}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {63'd0, ready}, 64'd1);

    // Table-driven vectors: normal packet, header-tail, orphans, lb=0 packet
    for (int i = 0; i < 9; i++) begin
      bcast = 1'(i);
      vc    = 1'(i >> 1);
      send_flit(tbl[i].ftype, tbl[i].fdata);
      if (tbl[i].has_beat) exp_q.push_back(tbl[i].beat);
      chk($sformatf("table_drop[%0d]", i), {48'd0, drop}, 64'(tbl[i].exp_drop));
    end
    bcast = '0; vc = '0;
    drain_and_compare("table");

    // Truncation by a new HEADER
    send_flit(T_H, hdr(8'h55, 4'd1, 4'd2, 4'd2));
    send_flit(T_B, 64'hA1);
    send_flit(T_H, hdr(8'h66, 4'd4, 4'd7, 4'd5));
    send_flit(T_B, 64'hA2);
    send_flit(T_T, 64'hA3);
    exp_q.push_back(mk(64'hA1, 8'hFF, 1'b0, 4'd2, 4'd1, 8'h55));
    exp_q.push_back(mk(64'h0,  8'h00, 1'b1, 4'd2, 4'd1, 8'h55));
    exp_q.push_back(mk(64'hA2, 8'hFF, 1'b0, 4'd7, 4'd4, 8'h66));
    exp_q.push_back(mk(64'hA3, 8'h1F, 1'b1, 4'd7, 4'd4, 8'h66));
    drain_and_compare("trunc_hdr");
    chk("trunc_hdr_drop", {48'd0, drop}, 64'd4);

    // Truncation by a HEADER_TAIL: close beat plus the new null beat
    send_flit(T_H,  hdr(8'h77, 4'd5, 4'd3, 4'd1));
    send_flit(T_B,  64'hB4);
    send_flit(T_HT, hdr(8'h78, 4'd6, 4'd4, 4'd0));
    exp_q.push_back(mk(64'hB4, 8'hFF, 1'b0, 4'd3, 4'd5, 8'h77));
    exp_q.push_back(mk(64'h0,  8'h00, 1'b1, 4'd3, 4'd5, 8'h77));
    exp_q.push_back(mk(64'h0,  8'h00, 1'b1, 4'd4, 4'd6, 8'h78));
    drain_and_compare("trunc_ht");
    chk("trunc_ht_drop", {48'd0, drop}, 64'd5);

    // DROP state left by a HEADER
    send_flit(T_B, 64'hC0);
    send_flit(T_H, hdr(8'h79, 4'd7, 4'd1, 4'd8));
    send_flit(T_T, 64'hC5);
    exp_q.push_back(mk(64'hC5, 8'hFF, 1'b1, 4'd1, 4'd7, 8'h79));
    drain_and_compare("drop_then_hdr");
    chk("drop_then_hdr_drop", {48'd0, drop}, 64'd6);

    // Throughput and latency with tready held high
    begin
      int c0;
      c0 = cycle;
      send_flit(T_H, hdr(8'h5A, 4'd2, 4'd3, 4'd4));
      send_flit(T_B, 64'h1000);
      chk("latency_tvalid", {63'd0, tvalid}, 64'd1);
      chk("latency_tdata",  tdata, 64'h1000);
      send_flit(T_B, 64'h1001);
      send_flit(T_B, 64'h1002);
      send_flit(T_B, 64'h1003);
      send_flit(T_T, 64'h1004);
      chk("throughput_cycles", 64'(cycle - c0), 64'd6);
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(64'h1000 + 64'(i), 8'hFF, 1'b0, 4'd3, 4'd2, 8'h5A));
      exp_q.push_back(mk(64'h1004, 8'h0F, 1'b1, 4'd3, 4'd2, 8'h5A));
      drain_and_compare("throughput");
    end

    // Random back-pressure over 200 packets
    bp_en = 1'b1;
    for (int p = 0; p < 200; p++) begin
      logic [7:0] s;
      logic [3:0] dst, id;
      int nb, lb;
      logic [63:0] d;
      s = 8'($urandom); dst = 4'($urandom); id = 4'($urandom);
      nb = $urandom_range(0, 3);
      lb = $urandom_range(0, 8);
      send_flit(T_H, hdr(s, dst, id, 4'(lb)));
      for (int b = 0; b < nb; b++) begin
        d = {$urandom, $urandom};
        send_flit(T_B, d);
        exp_q.push_back(mk(d, 8'hFF, 1'b0, id, dst, s));
      end
      d = {$urandom, $urandom};
      send_flit(T_T, d);
      exp_q.push_back(mk(d, keep_of(lb), 1'b1, id, dst, s));
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    drain_and_compare("random_bp");
    chk("random_bp_drop", {48'd0, drop}, 64'd6);

    // Asynchronous reset in the middle of a packet with a beat pending
    tready_idle = 1'b0;
    @(posedge clk);
    #1;
    send_flit(T_H, hdr(8'h21, 4'd1, 4'd1, 4'd0));
    send_flit(T_B, 64'hFEEDFACE);
    chk("pre_reset_tvalid", {63'd0, tvalid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_tvalid", {63'd0, tvalid}, 64'd0);
    chk("midreset_tdata",  tdata, 64'd0);
    chk("midreset_meta",   {35'd0, tkeep, tlast, tid, tdest, tuser}, 64'd0);
    chk("midreset_drop",   {48'd0, drop}, 64'd0);
    chk("midreset_ready",  {63'd0, ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tready_idle = 1'b1;
    @(posedge clk);
    #1;
    send_flit(T_H, hdr(8'h42, 4'd9, 4'd8, 4'd2));
    send_flit(T_B, 64'h7777);
    send_flit(T_T, 64'h8888);
    exp_q.push_back(mk(64'h7777, 8'hFF, 1'b0, 4'd8, 4'd9, 8'h42));
    exp_q.push_back(mk(64'h8888, 8'h03, 1'b1, 4'd8, 4'd9, 8'h42));
    drain_and_compare("after_reset");
    chk("after_reset_drop", {48'd0, drop}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
